agc_start_sequencer: RTL
========================

Name: agc_start_sequencer

Overview:
- Controller for the a2_timer start/stop/restart inputs (SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP); it replaces today's constant-0 tie-offs in agc.
- Sequences power-up start, alarm restart, ground restart, standby entry/exit and monitor stop/single-step from external requests.
- Watches timer feedback (T12, GOJAM) to close handshakes.
- Sits in agc between the request sources and a2_timer.

Parameters:
- STRT_CYCLES, 8: width in CLOCK cycles of the MSTRTP/STRT1 start pulse and of the STRT2 wake pulse; 1..255.
- GOJ1_CYCLES, 2: width of the ALGA and GOJ1 restart pulses; 1..15.
- SBY_WAIT_MCT, 2: T12 rising edges counted in SBY_PEND before SBY asserts; 1..15.
- GOJAM_TMO, 64: cycles allowed in RST_WAIT for the GOJAM high-then-low handshake; 2..1023.

Ports:
- CLOCK in 1: system clock; all logic on posedge.
- RESET in 1: synchronous, active-high reset.
- REQ_SBY in 1: level; request standby.
- REQ_WAKE in 1: level; request wake from standby.
- REQ_MSTOP in 1: level; monitor stop held while high.
- REQ_MSTEP in 1: one-cycle pulse; single-step while stopped.
- REQ_GOJ in 1: one-cycle pulse; ground restart.
- ALARM in 1: one-cycle pulse; alarm restart.
- T12 in 1: timer T12 pulse.
- GOJAM in 1: timer GOJAM.
- SBY out 1: to a2_timer.
- ALGA out 1: to a2_timer.
- MSTRTP out 1: to a2_timer.
- STRT1 out 1: to a2_timer.
- STRT2 out 1: to a2_timer.
- GOJ1 out 1: to a2_timer.
- MSTP out 1: to a2_timer.
- SEQ_STATE out 3: current state encoding.
- FAULT out 1: sticky; GOJAM handshake timeout.

Behaviour:
- All outputs are registered. While RESET is high: every output is 0, SEQ_STATE = IDLE (0), and all counters and edge-detect registers clear.
- IDLE(0): on the first cycle after RESET falls, go to START.
- START(1): MSTRTP = STRT1 = 1 for exactly STRT_CYCLES cycles, then RST_WAIT.
- RUN(2): all pulse outputs 0. Requests evaluated each cycle, priority ALARM > REQ_GOJ > REQ_MSTOP > REQ_SBY.
  - ALARM: ALGA = 1 for GOJ1_CYCLES cycles, then RST_WAIT.
  - REQ_GOJ: GOJ1 = 1 for GOJ1_CYCLES cycles, then RST_WAIT.
  - REQ_MSTOP: go to MSTOP; MSTP rises the next cycle.
  - REQ_SBY: go to SBY_PEND.
- RST_WAIT(3): wait for GOJAM to go high and then low; then RUN.
  - If GOJAM_TMO cycles elapse first: set FAULT and go to RUN.
  - FAULT clears only on RESET.
- SBY_PEND(4):
  - Count T12 rising edges (registered edge detect). At SBY_WAIT_MCT, go to STANDBY with SBY = 1.
  - REQ_SBY dropping before then returns to RUN with no SBY assertion.
  - ALARM or REQ_GOJ preempt SBY_PEND and are handled as in RUN.
- STANDBY(5):
  - SBY = 1.
  - REQ_WAKE → WAKE: SBY = 0 that cycle; STRT2 = 1 for STRT_CYCLES cycles; then RST_WAIT.
  - ALARM is ignored in STANDBY. REQ_GOJ forces the WAKE path.
- MSTOP(6):
  - MSTP = 1.
  - REQ_MSTEP: MSTP = 0 until the next T12 rising edge, then MSTP = 1 again. Further steps are ignored while a step is in flight.
  - REQ_MSTOP low → RUN; an in-flight step completes first.
  - ALARM or REQ_GOJ → MSTP = 0, then the restart path.
- State encoding: IDLE 0, START 1, RUN 2, RST_WAIT 3, SBY_PEND 4, STANDBY 5, MSTOP 6, WAKE 7. ALGA and GOJ1 pulses are sub-phases of RUN, SBY_PEND and MSTOP; SEQ_STATE is not a state of its own for them.
- Pulse counters reload on entry. A request arriving during a pulse or RST_WAIT is dropped, not queued.
- At most one of ALGA, GOJ1, MSTRTP and STRT2 is high in any cycle.
- RESET mid-sequence aborts immediately, back to IDLE.

Optional Feature:
- Macro RESTART_COUNTER_EN.
- Defined: adds output RST_COUNT [7:0].
  - Increments, saturating at 255, on each entry to RST_WAIT from ALGA or GOJ1. START and WAKE do not count.
  - Cleared by RESET.
- Undefined: port and logic are absent; no other behaviour changes.

Decomposition:
- Shared package agc_seq_pkg holds the 3-bit state enum and the STATE_* encodings, reused by the debug/monitor block.
- One sub-module, agc_pulse_gen: a loadable down-counter emitting a level of N cycles with a done strobe. It is instantiated once and shared, since only one pulse is ever active at a time.

Test Plan:
- Reset release, STRT_CYCLES = 8 → MSTRTP/STRT1 high cycles 1–8; GOJAM pulsed at cycle 12 → SEQ_STATE = RUN (2) the cycle after GOJAM falls.
- In RUN, ALARM and REQ_GOJ in the same cycle → ALGA high 2 cycles, GOJ1 never high; RST_WAIT entered.
- RST_WAIT with GOJAM held 0, GOJAM_TMO = 64 → FAULT = 1 after exactly 64 cycles, state RUN; FAULT persists until RESET.
- REQ_SBY held → SBY = 1 the cycle after the 2nd T12 edge; REQ_WAKE → SBY = 0, STRT2 high 8 cycles, then RST_WAIT.
- REQ_MSTOP held plus one REQ_MSTEP → MSTP low from the next cycle until the T12 edge, then high; a 2nd REQ_MSTEP during the step has no effect.
- With RESTART_COUNTER_EN: 300 ALARM restarts → RST_COUNT = 255.

Source files
------------

// File: rtl/agc_seq_pkg.sv
// Shared encodings for the AGC start/restart sequencer and its debug/monitor tap.
// SEQ_STATE values are fixed; the monitor decodes them directly.
package agc_seq_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE     = 3'd0,
    STATE_START    = 3'd1,
    STATE_RUN      = 3'd2,
    STATE_RST_WAIT = 3'd3,
    STATE_SBY_PEND = 3'd4,
    STATE_STANDBY  = 3'd5,
    STATE_MSTOP    = 3'd6,
    STATE_WAKE     = 3'd7
  } seq_state_e;

  // Restart pulse sub-phase layered on RUN / SBY_PEND / MSTOP.
  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_ALGA = 2'd1,
    PH_GOJ1 = 2'd2
  } rst_phase_e;

  typedef struct packed {
    logic sby;
    logic alga;
    logic mstrtp;
    logic strt1;
    logic strt2;
    logic goj1;
    logic mstp;
  } seq_out_t;

  localparam int PULSE_W = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/agc_pulse_gen.sv
// Loadable down-counter: holds 'active' for load_val cycles after a load,
// with 'done' marking the final active cycle.
import agc_seq_pkg::*;

module agc_pulse_gen #(
  parameter int W = PULSE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         active,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign active = (cnt_q != '0);
  assign done   = (cnt_q == W'(1));

endmodule

// File: rtl/agc_start_sequencer.sv
// Drives the a2_timer start/stop/restart inputs from external requests and closes
// the GOJAM handshake. Define RESTART_COUNTER_EN to add the RST_COUNT output.
import agc_seq_pkg::*;

module agc_start_sequencer #(
  parameter int STRT_CYCLES  = 8,
  parameter int GOJ1_CYCLES  = 2,
  parameter int SBY_WAIT_MCT = 2,
  parameter int GOJAM_TMO    = 64
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       REQ_SBY,
  input  logic       REQ_WAKE,
  input  logic       REQ_MSTOP,
  input  logic       REQ_MSTEP,
  input  logic       REQ_GOJ,
  input  logic       ALARM,
  input  logic       T12,
  input  logic       GOJAM,
  output logic       SBY,
  output logic       ALGA,
  output logic       MSTRTP,
  output logic       STRT1,
  output logic       STRT2,
  output logic       GOJ1,
  output logic       MSTP,
  output logic [2:0] SEQ_STATE,
  output logic       FAULT
`ifdef RESTART_COUNTER_EN
  ,
  output logic [7:0] RST_COUNT
`endif
);

  localparam logic [7:0] STRT_W   = 8'(STRT_CYCLES);
  localparam logic [7:0] GOJ1_W   = 8'(GOJ1_CYCLES);
  localparam logic [3:0] SBY_LAST = 4'(SBY_WAIT_MCT - 1);
  localparam logic [9:0] TMO_LAST = 10'(GOJAM_TMO - 1);

  seq_state_e state_q, state_d;
  rst_phase_e phase_q, phase_d;
  seq_out_t   out_q, out_d;
  logic [3:0] sby_cnt_q, sby_cnt_d;
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       gojam_seen_q, gojam_seen_d;
  logic       step_q, step_d;
  logic       fault_q, fault_d;
  logic       t12_prev_q;
  logic       t12_rise;
  logic       pg_load, pg_active, pg_done;
  logic [7:0] pg_val;
`ifdef RESTART_COUNTER_EN
  logic [7:0] rst_cnt_q, rst_cnt_d;
`endif

  // One counter serves every pulse; the FSM never overlaps them.
  agc_pulse_gen #(.W(8)) u_pulse (
    .clk      (CLOCK),
    .rst      (RESET),
    .load     (pg_load),
    .load_val (pg_val),
    .active   (pg_active),
    .done     (pg_done)
  );

  assign t12_rise = T12 & ~t12_prev_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sby_cnt_d    = sby_cnt_q;
    step_d       = step_q;
    fault_d      = fault_q;
    tmo_cnt_d    = '0;
    gojam_seen_d = 1'b0;
    pg_load      = 1'b0;
    pg_val       = STRT_W;
`ifdef RESTART_COUNTER_EN
    rst_cnt_d    = rst_cnt_q;
`endif

    case (state_q)
      STATE_IDLE: begin
        state_d = STATE_START;
        pg_load = 1'b1;
      end
      STATE_START, STATE_WAKE: begin
        if (pg_done) state_d = STATE_RST_WAIT;
      end
      STATE_RST_WAIT: begin
        tmo_cnt_d    = tmo_cnt_q + 10'd1;
        gojam_seen_d = gojam_seen_q | GOJAM;
        if (gojam_seen_q && !GOJAM) begin
          state_d = STATE_RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = STATE_RUN;
          fault_d = 1'b1;
        end
      end
      STATE_RUN, STATE_SBY_PEND, STATE_MSTOP: begin
        if (pg_active) begin
          // Requests arriving during a restart pulse are dropped.
          if (pg_done) begin
            state_d = STATE_RST_WAIT;
            phase_d = PH_NONE;
`ifdef RESTART_COUNTER_EN
            rst_cnt_d = sat_inc8(rst_cnt_q);
`endif
          end
        end else if (ALARM) begin
          phase_d = PH_ALGA;
          pg_load = 1'b1;
          pg_val  = GOJ1_W;
          step_d  = 1'b0;
        end else if (REQ_GOJ) begin
          phase_d = PH_GOJ1;
          pg_load = 1'b1;
          pg_val  = GOJ1_W;
          step_d  = 1'b0;
        end else begin
          case (state_q)
            STATE_RUN: begin
              if (REQ_MSTOP) begin
                state_d = STATE_MSTOP;
                step_d  = 1'b0;
              end else if (REQ_SBY) begin
                state_d   = STATE_SBY_PEND;
                sby_cnt_d = '0;
              end
            end
            STATE_SBY_PEND: begin
              if (!REQ_SBY) begin
                state_d = STATE_RUN;
              end else if (t12_rise) begin
                if (sby_cnt_q == SBY_LAST) state_d = STATE_STANDBY;
                else                       sby_cnt_d = sby_cnt_q + 4'd1;
              end
            end
            default: begin
              // MSTOP: a step in flight must finish before leaving.
              if (step_q) begin
                if (t12_rise) begin
                  step_d = 1'b0;
                  if (!REQ_MSTOP) state_d = STATE_RUN;
                end
              end else if (!REQ_MSTOP) begin
                state_d = STATE_RUN;
              end else if (REQ_MSTEP) begin
                step_d = 1'b1;
              end
            end
          endcase
        end
      end
      STATE_STANDBY: begin
        if (REQ_WAKE || REQ_GOJ) begin
          state_d = STATE_WAKE;
          pg_load = 1'b1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase

    out_d        = '0;
    out_d.sby    = (state_d == STATE_STANDBY);
    out_d.alga   = (phase_d == PH_ALGA);
    out_d.goj1   = (phase_d == PH_GOJ1);
    out_d.mstrtp = (state_d == STATE_START);
    out_d.strt1  = (state_d == STATE_START);
    out_d.strt2  = (state_d == STATE_WAKE);
    out_d.mstp   = (state_d == STATE_MSTOP) && (phase_d == PH_NONE) && !step_d;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= STATE_IDLE;
      phase_q      <= PH_NONE;
      out_q        <= '0;
      sby_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      gojam_seen_q <= 1'b0;
      step_q       <= 1'b0;
      fault_q      <= 1'b0;
      t12_prev_q   <= 1'b0;
`ifdef RESTART_COUNTER_EN
      rst_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      out_q        <= out_d;
      sby_cnt_q    <= sby_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gojam_seen_q <= gojam_seen_d;
      step_q       <= step_d;
      fault_q      <= fault_d;
      t12_prev_q   <= T12;
`ifdef RESTART_COUNTER_EN
      rst_cnt_q    <= rst_cnt_d;
`endif
    end
  end

  assign SBY       = out_q.sby;
  assign ALGA      = out_q.alga;
  assign MSTRTP    = out_q.mstrtp;
  assign STRT1     = out_q.strt1;
  assign STRT2     = out_q.strt2;
  assign GOJ1      = out_q.goj1;
  assign MSTP      = out_q.mstp;
  assign SEQ_STATE = state_q;
  assign FAULT     = fault_q;
`ifdef RESTART_COUNTER_EN
  assign RST_COUNT = rst_cnt_q;
`endif

endmodule
